// File: rtl/serial_to_parallel.sv
// -----------------------------------------------------------------------------
// serial_to_parallel
//
// Receive-side deserializer. Qualified serial bits are shifted into an N-bit
// assembly register. Each completed word is handed to a single-entry
// valid/ready holding register. A completed word that finds the holding
// register still full and not draining is dropped, and this sets a sticky
// overrun flag. sin_start realigns framing: the current bit becomes bit 1 of
// a fresh word.
//
// Parameters
//   N          word width in bits (N >= 2)
//   LSB_FIRST  0: first received bit lands in dout[N-1]; 1: lands in dout[0]
//
// Ports
//   clk          rising-edge clock
//   rstn         asynchronous active-low reset
//   sin          serial data bit, used only when sin_valid=1
//   sin_valid    qualifies sin this cycle
//   sin_start    with sin_valid, marks the first bit of a new word
//   dout         assembled word, held stable while dout_valid && !dout_ready
//   dout_valid   dout holds an unconsumed word
//   dout_ready   downstream accepts dout when dout_valid=1
//   overrun      sticky: a completed word was dropped
//   overrun_clr  clears overrun (a coincident drop wins)
//   busy         a partial word is in progress (bit count != 0)
// -----------------------------------------------------------------------------
module serial_to_parallel #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         sin,
  input  logic         sin_valid,
  input  logic         sin_start,
  output logic [N-1:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         overrun,
  input  logic         overrun_clr,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_LAST = cnt_t'(N - 1);
  localparam cnt_t CNT_ONE  = cnt_t'(1);

  logic [N-1:0] r_sr;
  cnt_t         r_cnt;
  logic [N-1:0] r_dout;
  logic         r_dout_valid;
  logic         r_overrun;

  logic [N-1:0] w_shifted;
  logic         w_complete;
  logic         w_accept;
  logic         w_drop;
  cnt_t         w_cnt_next;
  logic         w_dout_valid_next;
  logic         w_overrun_next;

  // The shift direction selects which end of dout the first bit lands in.
  // On a realignment the same shift is used. The bits left over from the
  // abandoned word fall out before the new word completes.
  assign w_shifted = LSB_FIRST ? {sin, r_sr[N-1:1]} : {r_sr[N-2:0], sin};

  // A start bit is always bit 1 of a word. It can never complete one, even
  // when the count happens to sit at N-1.
  assign w_complete = sin_valid && !sin_start && (r_cnt == CNT_LAST);

  // The holding register accepts a new word when it is empty or draining on
  // this same edge. A simultaneous drain and completion is not an overrun.
  assign w_accept = w_complete && (!r_dout_valid || dout_ready);
  assign w_drop   = w_complete && r_dout_valid && !dout_ready;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    w_cnt_next        = r_cnt;
    w_dout_valid_next = r_dout_valid;
    w_overrun_next    = r_overrun;

    if (sin_valid) begin
      if (sin_start) begin
        w_cnt_next = CNT_ONE;
      end else if (w_complete) begin
        w_cnt_next = '0;
      end else begin
        w_cnt_next = r_cnt + CNT_ONE;
      end
    end

    if (w_accept) begin
      w_dout_valid_next = 1'b1;
    end else if (r_dout_valid && dout_ready) begin
      w_dout_valid_next = 1'b0;
    end

    // The set term is tested first, so a drop in the same cycle as
    // overrun_clr leaves the flag asserted.
    if (w_drop) begin
      w_overrun_next = 1'b1;
    end else if (overrun_clr) begin
      w_overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sr         <= '0;
      r_cnt        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All registers
      // then update together from pre-edge values, whatever the statement order.
      if (sin_valid) begin
        r_sr <= w_shifted;
      end
      r_cnt        <= w_cnt_next;
      r_dout_valid <= w_dout_valid_next;
      r_overrun    <= w_overrun_next;
      if (w_accept) begin
        r_dout <= w_shifted;
      end
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_cnt != '0);

endmodule

// File: tb/tb_serial_to_parallel.sv
// -----------------------------------------------------------------------------
// tb_serial_to_parallel
//
// Directed bench for serial_to_parallel with N=8. Two instances share the
// same stimulus. u_msb is MSB-first and carries most of the checks. u_lsb is
// LSB-first and is checked where the bit order changes the expected word.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_serial_to_parallel;

  logic       clk;
  logic       rstn;
  logic       sin;
  logic       sin_valid;
  logic       sin_start;
  logic       dout_ready;
  logic       overrun_clr;

  logic [7:0] m_dout;
  logic       m_dout_valid;
  logic       m_overrun;
  logic       m_busy;
  logic [7:0] l_dout;
  logic       l_dout_valid;
  logic       l_overrun;
  logic       l_busy;

  int n_checks;
  int n_fail;

  serial_to_parallel #(.N(8), .LSB_FIRST(1'b0)) u_msb (
    .clk         (clk),
    .rstn        (rstn),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .sin_start   (sin_start),
    .dout        (m_dout),
    .dout_valid  (m_dout_valid),
    .dout_ready  (dout_ready),
    .overrun     (m_overrun),
    .overrun_clr (overrun_clr),
    .busy        (m_busy)
  );

  serial_to_parallel #(.N(8), .LSB_FIRST(1'b1)) u_lsb (
    .clk         (clk),
    .rstn        (rstn),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .sin_start   (sin_start),
    .dout        (l_dout),
    .dout_valid  (l_dout_valid),
    .dout_ready  (dout_ready),
    .overrun     (l_overrun),
    .overrun_clr (overrun_clr),
    .busy        (l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Send the top nbits of w, MSB of w first. The first bit can optionally
  // carry sin_start. The task returns right after the last sampling edge,
  // with sin_valid low.
  task automatic send_bits(input logic [7:0] w, input int nbits, input logic start);
    for (int i = 0; i < nbits; i++) begin
      sin       = w[7-i];
      sin_valid = 1'b1;
      sin_start = start && (i == 0);
      step();
    end
    sin_valid = 1'b0;
    sin_start = 1'b0;
  endtask

  initial begin
    logic [7:0] word;
    n_checks    = 0;
    n_fail      = 0;
    rstn        = 1'b0;
    sin         = 1'b0;
    sin_valid   = 1'b0;
    sin_start   = 1'b0;
    dout_ready  = 1'b1;
    overrun_clr = 1'b0;

    // Reset state
    step();
    check("rst_dout",    {24'd0, m_dout}, 32'h0);
    check("rst_valid",   {31'd0, m_dout_valid}, 32'h0);
    check("rst_overrun", {31'd0, m_overrun}, 32'h0);
    check("rst_busy",    {31'd0, m_busy}, 32'h0);
    #3 rstn = 1'b1;
    step();

    // MSB-first throughput with busy tracking (stream 1,0,1,0,0,1,0,1)
    word = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      sin       = word[7-i];
      sin_valid = 1'b1;
      sin_start = (i == 0);
      step();
      if (i < 7) begin
        check($sformatf("t1_busy_b%0d", i + 1), {31'd0, m_busy}, 32'h1);
        check($sformatf("t1_nvalid_b%0d", i + 1), {31'd0, m_dout_valid}, 32'h0);
      end
    end
    sin_valid = 1'b0;
    sin_start = 1'b0;
    check("t1_dout",  {24'd0, m_dout}, 32'hA5);
    check("t1_valid", {31'd0, m_dout_valid}, 32'h1);
    check("t1_busy0", {31'd0, m_busy}, 32'h0);
    check("t1_lsb_dout", {24'd0, l_dout}, 32'hA5);
    step();
    check("t1_valid_one_cycle", {31'd0, m_dout_valid}, 32'h0);

    // Gapped valid: three idle cycles between bits 4 and 5
    send_bits(8'hA5, 4, 1'b1);
    for (int g = 0; g < 3; g++) begin
      step();
      check($sformatf("t2_gap_busy%0d", g), {31'd0, m_busy}, 32'h1);
      check($sformatf("t2_gap_nvalid%0d", g), {31'd0, m_dout_valid}, 32'h0);
    end
    for (int i = 4; i < 8; i++) begin
      sin       = word[7-i];
      sin_valid = 1'b1;
      step();
      if (i == 6) check("t2_nvalid_b7", {31'd0, m_dout_valid}, 32'h0);
    end
    sin_valid = 1'b0;
    check("t2_dout",  {24'd0, m_dout}, 32'hA5);
    check("t2_valid", {31'd0, m_dout_valid}, 32'h1);
    step();
    check("t2_drained", {31'd0, m_dout_valid}, 32'h0);

    // Backpressure and overrun
    dout_ready = 1'b0;
    send_bits(8'hA5, 8, 1'b1);
    check("t3_dout_a5",  {24'd0, m_dout}, 32'hA5);
    check("t3_no_ovr",   {31'd0, m_overrun}, 32'h0);
    send_bits(8'h3C, 8, 1'b1);
    check("t3_dout_held", {24'd0, m_dout}, 32'hA5);
    check("t3_valid",     {31'd0, m_dout_valid}, 32'h1);
    check("t3_overrun",   {31'd0, m_overrun}, 32'h1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("t3_ovr_clr",   {31'd0, m_overrun}, 32'h0);
    check("t3_dout_keep", {24'd0, m_dout}, 32'hA5);
    check("t3_valid_keep", {31'd0, m_dout_valid}, 32'h1);

    // Drain coincident with completion of 0x3C
    send_bits(8'h3C, 7, 1'b1);
    check("t4_held_pre", {24'd0, m_dout}, 32'hA5);
    sin        = 1'b0;
    sin_valid  = 1'b1;
    dout_ready = 1'b1;
    step();
    sin_valid  = 1'b0;
    dout_ready = 1'b0;
    check("t4_dout_3c", {24'd0, m_dout}, 32'h3C);
    check("t4_valid",   {31'd0, m_dout_valid}, 32'h1);
    check("t4_no_ovr",  {31'd0, m_overrun}, 32'h0);

    // overrun_clr coincident with a drop: set wins
    send_bits(8'h81, 7, 1'b1);
    sin         = 1'b1;
    sin_valid   = 1'b1;
    overrun_clr = 1'b1;
    step();
    sin_valid   = 1'b0;
    overrun_clr = 1'b0;
    check("t4_set_wins", {31'd0, m_overrun}, 32'h1);
    check("t4_dout_kept", {24'd0, m_dout}, 32'h3C);
    overrun_clr = 1'b1;
    dout_ready  = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("t4_drain", {31'd0, m_dout_valid}, 32'h0);
    check("t4_clr",   {31'd0, m_overrun}, 32'h0);

    // Realignment: three stray bits, then a fresh start for 0x81
    send_bits(8'hE0, 3, 1'b1);
    check("t5_stray_busy", {31'd0, m_busy}, 32'h1);
    send_bits(8'h81, 8, 1'b1);
    check("t5_dout_81", {24'd0, m_dout}, 32'h81);
    check("t5_valid",   {31'd0, m_dout_valid}, 32'h1);
    check("t5_no_ovr",  {31'd0, m_overrun}, 32'h0);
    check("t5_lsb_81",  {24'd0, l_dout}, 32'h81);
    step();

    // LSB-first variant with stream 1,0,1,0,0,1,0,1
    send_bits(8'hA5, 8, 1'b1);
    check("t5_lsb_a5",   {24'd0, l_dout}, 32'hA5);
    check("t5_lsb_valid", {31'd0, l_dout_valid}, 32'h1);
    step();

    // Bit order distinguishes the instances: stream 0,0,0,0,0,0,0,1
    dout_ready = 1'b0;
    send_bits(8'h01, 8, 1'b1);
    check("t5_msb_01", {24'd0, m_dout}, 32'h01);
    check("t5_lsb_80", {24'd0, l_dout}, 32'h80);

    // Asynchronous reset mid-word, between clock edges
    send_bits(8'hFF, 5, 1'b1);
    check("t6_busy_pre", {31'd0, m_busy}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    check("t6_dout",    {24'd0, m_dout}, 32'h0);
    check("t6_valid",   {31'd0, m_dout_valid}, 32'h0);
    check("t6_overrun", {31'd0, m_overrun}, 32'h0);
    check("t6_busy",    {31'd0, m_busy}, 32'h0);
    check("t6_lsb_dout", {24'd0, l_dout}, 32'h0);
    #3 rstn = 1'b1;
    step();
    // No start flag: framing must come purely from the cleared bit count
    send_bits(8'h5A, 8, 1'b0);
    check("t6_dout_5a", {24'd0, m_dout}, 32'h5A);
    check("t6_valid_5a", {31'd0, m_dout_valid}, 32'h1);
    check("t6_no_ovr",  {31'd0, m_overrun}, 32'h0);
    check("t6_busy_end", {31'd0, m_busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
- Receive-side counterpart of the team's parallel-load, MSB-first serial shifter.
- Samples a qualified serial bit stream, assembles N-bit words, and presents each completed word on a valid/ready parallel output holding register.
- Provides sticky overrun detection and frame realignment.
- Sits at the link endpoint, feeding downstream parallel logic.

Parameters:
- N, 8, word width in bits; legal range N >= 2.
- LSB_FIRST, 0, bit order: 0 = first received bit is dout[N-1] (MSB-first, matches the transmitter); 1 = first received bit is dout[0].

Ports:
- clk  input  1  rising-edge clock for all state.
- rstn  input  1  asynchronous active-low reset.
- sin  input  1  serial data bit, sampled only when sin_valid=1.
- sin_valid  input  1  qualifies sin this cycle.
- sin_start  input  1  with sin_valid=1, marks this bit as the first bit of a new word; ignored when sin_valid=0.
- dout  output  N  assembled word; stable while dout_valid=1 and dout_ready=0.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  downstream accepts dout when dout_valid=1.
- overrun  output  1  sticky: a completed word was dropped.
- overrun_clr  input  1  clears overrun.
- busy  output  1  partial word in progress (bit count != 0).

Behaviour:
- Reset (async assert, sync release): shift register=0, bit count=0, dout=0, dout_valid=0, overrun=0, busy=0. Reset mid-word discards the partial word and any held word.
- Internal state: shift register sr[N-1:0]; bit count cnt, width clog2(N), range 0..N-1.
- sin_valid=0: no change to sr or cnt; no timeout.
- sin_valid=1, sin_start=0:
  - LSB_FIRST=0: sr <= {sr[N-2:0], sin}.
  - LSB_FIRST=1: sr <= {sin, sr[N-1:1]}.
  - cnt <= cnt+1.
- sin_valid=1, sin_start=1: the partial word is abandoned without a flag. sin becomes bit 1 of the new word (sr shifts as above; stale bits are don't-care) and cnt <= 1.
- Word complete: sin_valid=1, sin_start=0, cnt==N-1.
  - The assembled word is the shifted value that includes this sin.
  - cnt wraps to 0.
- Output buffer on word complete:
  - If dout_valid=0, or dout_valid=1 and dout_ready=1 in the same cycle: dout <= word and dout_valid <= 1 next cycle. Simultaneous drain and complete does not overrun.
  - Otherwise: word dropped, dout unchanged, overrun <= 1.
- Latency: dout_valid rises on the clock edge that samples the Nth bit, i.e. visible in the cycle after the Nth bit is presented.
- Handshake:
  - Transfer occurs on any edge with dout_valid=1 and dout_ready=1.
  - On transfer with no word completing, dout_valid <= 0 and dout keeps its value.
  - dout_ready while dout_valid=0 has no effect.
- overrun:
  - Set by a dropped word.
  - Cleared by overrun_clr=1.
  - Set and clear in the same cycle: set wins (overrun stays 1).
- busy = (cnt != 0), registered view of cnt.

Test Plan:
- MSB-first throughput. N=8, LSB_FIRST=0, dout_ready=1. Drive sin 1,0,1,0,0,1,0,1 on consecutive cycles with sin_start on the first bit. Required: dout=8'hA5 and dout_valid=1 for exactly one cycle, starting the cycle after the 8th bit; busy=1 during bits 2..8, then 0.
- Gapped valid. Same stream with sin_valid low for 3 cycles between bits 4 and 5. Required: dout=8'hA5, with dout_valid appearing only after the 8th qualified bit.
- Backpressure and overrun. dout_ready=0; send 0xA5, then 0x3C. Required: dout stays 8'hA5, dout_valid=1, overrun=1 after the 0x3C word completes. Then pulse overrun_clr. Required: overrun=0 and dout still 8'hA5.
- Drain coincident with completion. Hold 0xA5 with dout_ready=0; raise dout_ready exactly on the cycle the 8th bit of 0x3C is presented. Required: 0xA5 transfers, next cycle dout=8'h3C with dout_valid=1, overrun=0. Also pulse overrun_clr coincident with a drop. Required: overrun=1.
- Realignment. Send 3 bits 1,1,1, then assert sin_start with the stream for 0x81. Required: dout=8'h81, no overrun. LSB_FIRST=1 variant with the same bit stream 1,0,1,0,0,1,0,1: dout=8'hA5.
- Reset mid-word. After 5 bits, pulse rstn low asynchronously between edges. Required: all outputs 0 immediately. Then send a full 0x5A. Required: dout=8'h5A with no residue from the partial word.
